periph_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the memory-mapped peripheral bus (read/write/address/write_data/read_data/response).
- Lets the CPU data port (master 0) and a DMA/debug port (master 1) share the peripheral bus feeding the LED, GPIO and similar devices.
- Arbitrates round-robin and latches the winning command.
- Holds the command on the slave side until the slave responds or a timeout fires; a timeout returns an error word.

---
 rtl/periph_bus_pkg.sv | 23 ++
 rtl/periph_bus_arbiter_rr_arbiter2.sv | 25 ++
 rtl/periph_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_periph_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg
//   Shared types and defaults for the two-master peripheral bus arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BUSY)
//   bus_cmd_t   : latched command presented to the slave
//   DEFAULT_TIMEOUT / DEFAULT_ERROR_DATA : parameter defaults for the top
package periph_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] write_data;
  } bus_cmd_t;

  localparam int          DEFAULT_TIMEOUT    = 16;
  localparam logic [31:0] DEFAULT_ERROR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/periph_bus_arbiter_rr_arbiter2.sv
// rr_arbiter2
//   Two-requester round-robin pick, purely combinational.
//   req_i[1:0]   : request per requester
//   last_grant_i : index of the requester served most recently
//   grant_o      : index of the winner (meaningful only when valid_o)
//   valid_o      : at least one requester is asking
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       valid_o
);

  // On a tie the requester that did not go last wins; otherwise the lone
  // requester wins (req_i[1] doubles as its index).
  always_comb begin
    valid_o = |req_i;
    if (req_i == 2'b11) begin
      grant_o = ~last_grant_i;
    end else begin
      grant_o = req_i[1];
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter
//   Shares one peripheral slave between the CPU data port (master 0) and a
//   DMA/debug port (master 1). Round-robin grant, latched command, per-
//   transaction timeout that returns ERROR_DATA and sets a sticky bus_error.
//   Ports:
//     clk, rst_n                 : clock, asynchronous active-low reset
//     m_read/m_write [1:0]       : per-master request (write wins if both)
//     m_address/m_write_data     : per-master command fields
//     m_read_data/m_response     : per-master completion data and pulse
//     s_read/s_write/s_address/s_write_data : registered slave command
//     s_read_data/s_response     : slave return path
//     err_clear/bus_error        : sticky timeout flag and its clear
//     grant                      : master currently or last granted
module periph_bus_arbiter
  import periph_bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter logic [31:0] ERROR_DATA     = DEFAULT_ERROR_DATA
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       m_read,
  input  logic [1:0]       m_write,
  input  logic [1:0][31:0] m_address,
  input  logic [1:0][31:0] m_write_data,
  output logic [1:0][31:0] m_read_data,
  output logic [1:0]       m_response,
  output logic             s_read,
  output logic             s_write,
  output logic [31:0]      s_address,
  output logic [31:0]      s_write_data,
  input  logic [31:0]      s_read_data,
  input  logic             s_response,
  input  logic             err_clear,
  output logic             bus_error,
  output logic             grant
);

  // The counter only has to reach TIMEOUT_CYCLES-1.
  localparam int             CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t       state_q, state_d;
  bus_cmd_t         cmd_q, cmd_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_error_q, bus_error_d;

  logic [1:0]  req;
  logic        arb_grant;
  logic        arb_valid;
  logic        done;
  logic        timed_out;
  logic        finish;
  logic [31:0] rsp_data;

  assign req = m_read | m_write;

  rr_arbiter2 u_rr (
    .req_i       (req),
    .last_grant_i(last_grant_q),
    .grant_o     (arb_grant),
    .valid_o     (arb_valid)
  );

  // A slave response in the final counted cycle beats the timeout.
  always_comb begin
    done      = (state_q == BUSY) && s_response;
    timed_out = (state_q == BUSY) && !s_response && (cnt_q == CNT_LAST);
    finish    = done || timed_out;
  end

  // Completion path back to the granted master; the other master sees 0.
  always_comb begin
    m_response  = '0;
    m_read_data = '0;
    rsp_data    = '0;
    if (done) begin
      rsp_data = cmd_q.read ? s_read_data : 32'h0;
    end else if (timed_out) begin
      rsp_data = cmd_q.read ? ERROR_DATA : 32'h0;
    end
    if (finish) begin
      m_response[grant_q]  = 1'b1;
      m_read_data[grant_q] = rsp_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    bus_error_d  = bus_error_q;

    if (state_q == IDLE) begin
      if (arb_valid) begin
        // A simultaneous read+write from one master is taken as a write.
        cmd_d.write      = m_write[arb_grant];
        cmd_d.read       = m_read[arb_grant] & ~m_write[arb_grant];
        cmd_d.address    = m_address[arb_grant];
        cmd_d.write_data = m_write_data[arb_grant];
        grant_d          = arb_grant;
        cnt_d            = '0;
        state_d          = BUSY;
      end
    end else begin
      if (finish) begin
        // Strobes drop on the completion edge; address/data may linger.
        cmd_d.read   = 1'b0;
        cmd_d.write  = 1'b0;
        last_grant_d = grant_q;
        cnt_d        = '0;
        state_d      = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Setting on timeout takes priority over a coincident clear.
    if (timed_out) begin
      bus_error_d = 1'b1;
    end else if (err_clear) begin
      bus_error_d = 1'b0;
    end
  end

  // last_grant resets to 1 so that master 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      bus_error_q  <= bus_error_d;
    end
  end

  assign s_read       = cmd_q.read;
  assign s_write      = cmd_q.write;
  assign s_address    = cmd_q.address;
  assign s_write_data = cmd_q.write_data;
  assign bus_error    = bus_error_q;
  assign grant        = grant_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter
//   Self-checking bench for periph_bus_arbiter. A transaction-level model
//   (who should win, what the slave should see, what comes back) is kept in
//   a few variables and compared against the DUT at every cycle.
module tb_periph_bus_arbiter;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] ERR     = 32'hDEADBEEF;

  logic             clk;
  logic             rst_n;
  logic [1:0]       m_read;
  logic [1:0]       m_write;
  logic [1:0][31:0] m_address;
  logic [1:0][31:0] m_write_data;
  logic [1:0][31:0] m_read_data;
  logic [1:0]       m_response;
  logic             s_read;
  logic             s_write;
  logic [31:0]      s_address;
  logic [31:0]      s_write_data;
  logic [31:0]      s_read_data;
  logic             s_response;
  logic             err_clear;
  logic             bus_error;
  logic             grant;

  int   checkCount = 0;
  int   passCount  = 0;
  int   failCount  = 0;
  int   expLastGrant;
  logic expGrant;
  logic expBusError;

  periph_bus_arbiter #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .ERROR_DATA    (ERR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m_read      (m_read),
    .m_write     (m_write),
    .m_address   (m_address),
    .m_write_data(m_write_data),
    .m_read_data (m_read_data),
    .m_response  (m_response),
    .s_read      (s_read),
    .s_write     (s_write),
    .s_address   (s_address),
    .s_write_data(s_write_data),
    .s_read_data (s_read_data),
    .s_response  (s_response),
    .err_clear   (err_clear),
    .bus_error   (bus_error),
    .grant       (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] rd, input logic [1:0] wr,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1);
    m_read          = rd;
    m_write         = wr;
    m_address[0]    = a0;
    m_address[1]    = a1;
    m_write_data[0] = d0;
    m_write_data[1] = d1;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    s_response  = 1'b0;
    s_read_data = 32'h0;
    err_clear   = 1'b0;
    @(negedge clk);
    rst_n        = 1'b1;
    expLastGrant = 1;
    expGrant     = 1'b0;
    expBusError  = 1'b0;
  endtask

  // One full transaction starting from an IDLE cycle. waitCycles >= TIMEOUT
  // means the slave never answers.
  task automatic runTxn(input logic [1:0] rd, input logic [1:0] wr,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input int waitCycles, input logic [31:0] slaveData,
                        input bit clrAtEnd);
    int               win;
    logic             isRead;
    logic             isWrite;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [1:0]       req;
    bit               respNow;
    bit               last;
    logic [1:0][31:0] expRd;

    req = rd | wr;
    if (req == 2'b11) win = 1 - expLastGrant;
    else              win = req[1] ? 1 : 0;
    isWrite = wr[win];
    isRead  = rd[win] && !isWrite;
    addr    = (win == 1) ? a1 : a0;
    wdata   = (win == 1) ? d1 : d0;

    @(negedge clk);
    applyStimulus(rd, wr, a0, a1, d0, d1);
    s_response = 1'b0;
    err_clear  = 1'b0;
    #1;
    checkOutput("idle_strobes", {s_read, s_write}, 2'b00);
    checkOutput("idle_m_response", m_response, 2'b00);
    checkOutput("idle_grant", grant, expGrant);
    checkOutput("idle_bus_error", bus_error, expBusError);

    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      respNow     = (k == waitCycles + 1);
      last        = respNow || (k == TIMEOUT);
      s_response  = respNow;
      s_read_data = respNow ? slaveData : $urandom;
      err_clear   = last && clrAtEnd;
      if (k == 2) begin
        m_address[win]    = ~addr;
        m_write_data[win] = wdata ^ 32'hFFFF0000;
      end
      #1;
      checkOutput("busy_strobes", {s_read, s_write}, {isRead, isWrite});
      checkOutput("busy_s_address", s_address, addr);
      checkOutput("busy_s_write_data", s_write_data, wdata);
      checkOutput("busy_grant", grant, win[0]);
      expRd = '0;
      if (last) expRd[win] = !isRead ? 32'h0 : (respNow ? slaveData : ERR);
      checkOutput("busy_m_response", m_response, last ? (64'd1 << win) : 64'd0);
      checkOutput("busy_m_read_data", m_read_data, expRd);
      if (last) begin
        expLastGrant = win;
        expGrant     = win[0];
        if (!respNow)     expBusError = 1'b1;
        else if (clrAtEnd) expBusError = 1'b0;
        break;
      end
    end
  endtask

  task automatic idleCycle(input bit clr);
    @(negedge clk);
    applyStimulus(2'b00, 2'b00, $urandom, $urandom, $urandom, $urandom);
    s_response = 1'b0;
    err_clear  = clr;
    #1;
    checkOutput("gap_strobes", {s_read, s_write}, 2'b00);
    checkOutput("gap_m_response", m_response, 2'b00);
    checkOutput("gap_m_read_data", m_read_data, 64'h0);
    checkOutput("gap_grant", grant, expGrant);
    checkOutput("gap_bus_error", bus_error, expBusError);
    if (clr) expBusError = 1'b0;
  endtask

  initial begin
    logic [1:0] rd;
    logic [1:0] wr;
    int         w;

    rst_n = 1'b0;
    applyStimulus(2'b11, 2'b00, 32'h1234, 32'h5678, 32'h1, 32'h2);
    s_response  = 1'b1;
    s_read_data = 32'hFFFF;
    err_clear   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_strobes", {s_read, s_write}, 2'b00);
    checkOutput("reset_s_address", s_address, 32'h0);
    checkOutput("reset_s_write_data", s_write_data, 32'h0);
    checkOutput("reset_m_response", m_response, 2'b00);
    checkOutput("reset_m_read_data", m_read_data, 64'h0);
    checkOutput("reset_bus_error", bus_error, 1'b0);
    checkOutput("reset_grant", grant, 1'b0);
    resetDut();

    // Zero-wait single read from master 0.
    runTxn(2'b01, 2'b00, 32'h1000, 32'h0, 32'h0, 32'h0, 0, 32'h000000A5, 1'b0);
    idleCycle(1'b0);

    // Simultaneous writes right after reset: master 0 first, then master 1.
    resetDut();
    runTxn(2'b00, 2'b11, 32'h3000, 32'h3004, 32'h11, 32'h22, 0, 32'h0, 1'b0);
    runTxn(2'b00, 2'b11, 32'h3000, 32'h3004, 32'h11, 32'h22, 1, 32'h0, 1'b0);

    // Both masters requesting back to back: grants must alternate.
    for (int n = 0; n < 6; n++) begin
      rd = 2'($urandom);
      wr = ~rd | 2'($urandom);
      runTxn(rd, wr, $urandom, $urandom, $urandom, $urandom,
             $urandom_range(0, 2), $urandom, 1'b0);
    end
    idleCycle(1'b0);

    // Master 1 read to a silent slave, then clear the sticky error.
    runTxn(2'b10, 2'b00, 32'h0, 32'h8000, 32'h0, 32'h0, TIMEOUT, 32'h0, 1'b0);
    idleCycle(1'b0);
    idleCycle(1'b1);
    idleCycle(1'b0);

    // Three wait states with the address changing mid-transaction.
    runTxn(2'b01, 2'b00, 32'h4000, 32'h0, 32'h0, 32'h0, 3, 32'h5A5A5A5A, 1'b0);
    idleCycle(1'b0);

    // Response in the very last counted cycle is not a timeout.
    runTxn(2'b00, 2'b01, 32'h4400, 32'h0, 32'hCAFE, 32'h0, TIMEOUT - 1, 32'h0, 1'b0);
    idleCycle(1'b0);

    // Timeout and err_clear on the same edge: the flag stays set.
    runTxn(2'b01, 2'b00, 32'h4800, 32'h0, 32'h0, 32'h0, TIMEOUT, 32'h0, 1'b1);
    idleCycle(1'b0);

    // Asynchronous reset in the middle of a write.
    @(negedge clk);
    applyStimulus(2'b00, 2'b01, 32'h2000, 32'h0, 32'h55, 32'h0);
    s_response = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("pre_reset_s_write", s_write, 1'b1);
    #1 rst_n = 1'b0;
    #1 s_response = 1'b1;
    s_read_data = 32'h77;
    #1;
    checkOutput("async_reset_strobes", {s_read, s_write}, 2'b00);
    checkOutput("async_reset_m_response", m_response, 2'b00);
    checkOutput("async_reset_m_read_data", m_read_data, 64'h0);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    s_response   = 1'b0;
    expLastGrant = 1;
    expGrant     = 1'b0;
    expBusError  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    runTxn(2'b11, 2'b00, 32'h5000, 32'h5004, 32'h0, 32'h0, 0, 32'h99, 1'b0);
    idleCycle(1'b0);

    // Randomized traffic against the transaction-level model.
    for (int n = 0; n < 24; n++) begin
      rd = 2'($urandom);
      wr = 2'($urandom);
      if ((rd | wr) == 2'b00) rd = 2'b01;
      w = ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(0, 4);
      runTxn(rd, wr, $urandom, $urandom, $urandom, $urandom, w, $urandom,
             1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idleCycle(1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
